fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the Harvard pipeline. It sits between the instruction memory port and the decode stage. It issues sequential fetch requests over a ready/valid request channel and absorbs variable memory latency with in-order responses. It buffers up to DEPTH fetched instructions with their PCs, and squashes in-flight and buffered fetches on a branch/jump redirect.

---
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch, in-order response buffer,
// DEPTH-entry {instr,pc} queue to decode, flush on redirect.
//
// Ports:
//   i_clk, i_resetn           clock, async active-low reset
//   o_imem_req/o_imem_addr    fetch request channel (i_imem_ready accepts)
//   i_imem_rvalid/i_imem_rdata in-order fetch responses
//   o_valid/o_instr/o_pc      queue head toward decode (i_ready pops)
//   i_redirect/i_redirect_pc  flush and restart fetch
module fetch_queue #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = 'h13
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic [CW:0]     inflight;
  logic            issue;
  logic            rsp;
  logic            drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redir_pc;
  logic [CW-1:0]   ostd_left;

  // Queue slots plus in-flight fetches may never exceed DEPTH,
  // so every response is guaranteed a free slot.
  assign inflight = {1'b0, count} + {1'b0, outstanding};

  assign o_imem_req = i_resetn && !i_redirect
                    && (inflight < (CW+1)'(DEPTH));
  assign o_imem_addr = f_pc;

  assign issue = o_imem_req && i_imem_ready;
  // A response with nothing outstanding is a protocol error: ignore it.
  assign rsp   = i_imem_rvalid && (outstanding != '0);
  assign drop  = rsp && (drop_cnt != '0);
  assign push  = rsp && !drop && !i_redirect;
  assign pop   = o_valid && i_ready && !i_redirect;

  assign redir_pc  = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign ostd_left = outstanding - CW'(rsp);

  assign o_valid = (count != '0);
  assign o_instr = o_valid ? q_instr[head] : NOP_INSTR;
  assign o_pc    = o_valid ? q_pc[head] : r_pc;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      f_pc        <= RESET_PC;
      r_pc        <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= NOP_INSTR;
        q_pc[i]    <= RESET_PC;
      end
    end else if (i_redirect) begin
      // Everything still in flight becomes stale and is dropped.
      f_pc        <= redir_pc;
      r_pc        <= redir_pc;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= ostd_left;
      drop_cnt    <= ostd_left;
    end else begin
      if (issue) begin
        f_pc <= f_pc + XLEN'(4);
      end
      outstanding <= outstanding + CW'(issue) - CW'(rsp);
      if (drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        q_instr[tail] <= i_imem_rdata;
        q_pc[tail]    <= r_pc;
        tail          <= tail + AW'(1);
        r_pc          <= r_pc + XLEN'(4);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_rsp_ostd: assert property (
    @(posedge i_clk) disable iff (!i_resetn)
    i_imem_rvalid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a
// fixed-latency in-order memory model, mem[a] = a | 0x1000_0000.
module tb_fetch_queue;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] TAG = 32'h1000_0000;

  logic            clk = 1'b0;
  logic            resetn;
  logic            req;
  logic [XLEN-1:0] addr;
  logic            mem_ready;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  logic            o_valid;
  logic [XLEN-1:0] o_instr;
  logic [XLEN-1:0] o_pc;
  logic            dec_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .RESET_PC(32'h0),
    .NOP_INSTR(32'h13)
  ) dut (
    .i_clk(clk),
    .i_resetn(resetn),
    .o_imem_req(req),
    .o_imem_addr(addr),
    .i_imem_ready(mem_ready),
    .i_imem_rvalid(rvalid),
    .i_imem_rdata(rdata),
    .o_valid(o_valid),
    .o_instr(o_instr),
    .o_pc(o_pc),
    .i_ready(dec_ready),
    .i_redirect(redirect),
    .i_redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_pc[$];
  int          lat = 1;
  int          cyc_n = 0;
  int          pops = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_mem();
    if (mq.size() > 0 && mq[0].due <= cyc_n) begin
      rvalid = 1'b1;
      rdata  = mq[0].a | TAG;
    end else begin
      rvalid = 1'b0;
      rdata  = 32'hdead_beef;
    end
  endtask

  task automatic step();
    logic        acc;
    logic        rv;
    logic        pp;
    logic        rd;
    logic [31:0] a;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] e;
    #1;
    acc = req && mem_ready;
    a   = addr;
    rv  = rvalid;
    rd  = redirect && resetn;
    pp  = o_valid && dec_ready && !redirect && resetn;
    pc  = o_pc;
    ins = o_instr;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rv && mq.size() > 0) void'(mq.pop_front());
    if (acc) mq.push_back('{a: a, due: cyc_n - 1 + lat});
    if (rd) exp_pc.delete();
    if (pp) begin
      pops++;
      e = 32'hffff_ffff;
      if (exp_pc.size() > 0) e = exp_pc.pop_front();
      check("sb_pc", pc, e);
      check("sb_instr", ins, e | TAG);
    end
    if (acc && !rd) exp_pc.push_back(a);
    drive_mem();
  endtask

  task automatic reset_dut();
    resetn   = 1'b0;
    redirect = 1'b0;
    rvalid   = 1'b0;
    #1;
    mq.delete();
    exp_pc.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc_n  = 0;
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!o_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, o_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    resetn      = 1'b0;
    dec_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_ready   = 1'b1;
    rvalid      = 1'b0;
    rdata       = '0;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_instr", o_instr, 32'h13);
    check("rst_pc", o_pc, 0);
    check("rst_req", req, 0);
    check("rst_addr", addr, 0);

    // Streaming after reset release
    repeat (2) @(posedge clk);
    #1;
    resetn    = 1'b1;
    dec_ready = 1'b1;
    cyc_n     = 0;
    #1;
    check("first_req", req, 1);
    step();
    check("valid_c1", o_valid, 0);
    step();
    check("valid_c2", o_valid, 1);
    check("pc_c2", o_pc, 0);
    check("instr_c2", o_instr, TAG);
    pops = 0;
    repeat (8) step();
    check("thruput", pops, 8);

    // Decode stall fills the queue and throttles requests
    dec_ready = 1'b0;
    reset_dut();
    repeat (10) step();
    check("stall_req", req, 0);
    check("stall_valid", o_valid, 1);
    check("stall_pc", o_pc, 0);
    dec_ready = 1'b1;
    pops = 0;
    repeat (12) step();
    check("stall_drain", pops >= 4, 1);

    // 3-cycle memory, 3 outstanding, redirect drops them all
    reset_dut();
    lat = 3;
    repeat (3) step();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    #1;
    check("redir_req", req, 0);
    step();
    redirect = 1'b0;
    check("redir_v1", o_valid, 0);
    check("redir_addr", addr, 32'h40);
    wait_valid("redir_wait");
    check("redir_pc", o_pc, 32'h40);
    check("redir_instr", o_instr, TAG | 32'h40);
    repeat (6) step();

    // Redirect alongside a pop and a response
    reset_dut();
    lat = 1;
    repeat (6) step();
    check("busy_cycle", o_valid && rvalid, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    check("n1_valid", o_valid, 0);
    check("n1_addr", addr, 32'h80);
    step();
    check("n2_valid", o_valid, 0);
    step();
    check("n3_valid", o_valid, 1);
    check("n3_pc", o_pc, 32'h80);
    check("n3_instr", o_instr, TAG | 32'h80);
    repeat (5) step();

    // Unaligned redirect target
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    step();
    redirect = 1'b0;
    check("unal_addr", addr, 32'h40);
    wait_valid("unal_wait");
    check("unal_pc", o_pc, 32'h40);
    repeat (4) step();

    // Asynchronous reset mid-burst
    dec_ready = 1'b0;
    reset_dut();
    lat = 3;
    repeat (5) step();
    check("burst_valid", o_valid, 1);
    resetn = 1'b0;
    rvalid = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_instr", o_instr, 32'h13);
    check("arst_pc", o_pc, 0);
    check("arst_req", req, 0);
    mq.delete();
    exp_pc.delete();
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    cyc_n     = 0;
    lat       = 1;
    dec_ready = 1'b1;
    wait_valid("rst2_wait");
    check("rst2_pc", o_pc, 0);
    check("rst2_instr", o_instr, TAG);
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
